allophone_fifo: RTL and testbench

Input command buffer between the host load interface and the sequencing controller. It accepts allophone codes from the host as single-cycle load strobes and stores them in order. It presents the oldest code to the controller in the 8-bit format consumed by the allophone-to-ROM-address translator (bit 7 always 0), and reports load-request / buffer status back to the host in SP0256 style.

---
 rtl/allophone_fifo_if.sv | 27 ++
 rtl/allophone_fifo.sv | 79 +++++++
 tb/tb_allophone_fifo.sv | 137 +++++++++++++
 3 files changed

// File: rtl/allophone_fifo_if.sv
// Host/controller-facing bundle of the allophone command buffer.
// master = host + controller side (drives codes, strobes, acks, flush).
// slave  = the buffer itself (returns head code, load request and status).
interface allophone_fifo_if #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 4
);
  logic [7:0]      allo_data;
  logic            allo_strobe;
  logic            flush;
  logic            c8_ack;
  logic            ldq;
  logic            overflow;
  logic [7:0]      c8_out;
  logic            c8_valid;
  logic [CNTW-1:0] count;

  modport master (
    output allo_data, allo_strobe, flush, c8_ack,
    input  ldq, overflow, c8_out, c8_valid, count
  );

  modport slave (
    input  allo_data, allo_strobe, flush, c8_ack,
    output ldq, overflow, c8_out, c8_valid, count
  );
endinterface

// File: rtl/allophone_fifo.sv
// Purpose: in-order buffer of 7-bit allophone codes between host load strobes and the sequencer.
// Latency: a code strobed at edge N is visible at c8_out after edge N; ack advances the head at the edge.
// Backpressure: ldq drops while full; a strobe while full without a same-cycle ack is dropped and sets sticky overflow.
module allophone_fifo #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 4
) (
  input logic             clk,
  input logic             rst_an,
  allophone_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [6:0]      mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, empty, push, pop;
  logic            unused_bit7;

  // Bit 7 of the host code carries no meaning for the translator.
  assign unused_bit7 = bus.allo_data[7];

  // Accept decisions: a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full  = (cnt_q == FULL_CNT);
    empty = (cnt_q == '0);
    pop   = bus.c8_ack && !empty;
    push  = bus.allo_strobe && (!full || pop);
  end

  // Next-state for pointers, occupancy and the sticky overflow flag; flush wins.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (bus.flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CNTW'(1);
      else if (pop && !push) cnt_d = cnt_q - CNTW'(1);
      if (bus.allo_strobe && !push) ovf_d = 1'b1;
    end
  end

  // Control state, cleared asynchronously so status is valid before any clock.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage array; contents are never cleared since the output is gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) mem_q[wp_q] <= bus.allo_data[6:0];
  end

  assign bus.ldq      = !full;
  assign bus.c8_valid = !empty;
  assign bus.c8_out   = empty ? 8'h00 : {1'b0, mem_q[rp_q]};
  assign bus.count    = cnt_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_allophone_fifo.sv
// Directed bench for allophone_fifo with a reference queue model.
// Expected codes are queued on accepted strobes and compared when acked.
module tb_allophone_fifo;
  localparam int DEPTH = 8;
  localparam int CNTW  = 4;

  logic clk = 1'b0;
  logic rst_an = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  logic [6:0] q[$];
  logic       m_ovf = 1'b0;

  allophone_fifo_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  allophone_fifo #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_an(rst_an),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model state.
  task automatic chk_state(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 32'(q.size()));
    chk({tag, ".ldq"}, 32'(bus.ldq), 32'(q.size() < DEPTH));
    chk({tag, ".valid"}, 32'(bus.c8_valid), 32'(q.size() > 0));
    chk({tag, ".c8_out"}, 32'(bus.c8_out), (q.size() == 0) ? 32'h0 : {25'd0, q[0]});
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
  endtask

  // One clock: drive inputs, check the acked head before the edge, update model, check after.
  task automatic cyc(input logic s, input logic [7:0] d, input logic a, input logic f, input string tag);
    logic pop_ok, push_ok;
    bus.allo_strobe = s;
    bus.allo_data   = d;
    bus.c8_ack      = a;
    bus.flush       = f;
    pop_ok  = a && (q.size() > 0);
    push_ok = s && ((q.size() < DEPTH) || pop_ok);
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop_ok) begin
        chk({tag, ".head"}, 32'(bus.c8_out), {25'd0, q[0]});
        void'(q.pop_front());
      end
      if (push_ok) q.push_back(d[6:0]);
      if (s && !push_ok) m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.allo_strobe = 1'b0;
    bus.c8_ack      = 1'b0;
    bus.flush       = 1'b0;
    chk_state(tag);
  endtask

  initial begin
    bus.allo_data   = 8'h00;
    bus.allo_strobe = 1'b0;
    bus.flush       = 1'b0;
    bus.c8_ack      = 1'b0;

    // Reset state before any clock edge.
    #1;
    chk_state("reset0");
    @(posedge clk);
    #1;
    rst_an = 1'b1;

    // Basic order, bit 7 stripped.
    cyc(1, 8'h85, 0, 0, "p85");
    cyc(1, 8'h2A, 0, 0, "p2A");
    cyc(1, 8'h7F, 0, 0, "p7F");
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, "ack3");
    cyc(0, 8'h00, 1, 0, "ack_empty");

    // Fill past full: ninth dropped, overflow sticky through drain.
    for (int i = 1; i <= 9; i++) cyc(1, 8'(i), 0, 0, "fill9");
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, "drain8");
    cyc(0, 8'h00, 0, 1, "flush_ovf");

    // Full with strobe and ack together.
    for (int i = 1; i <= 8; i++) cyc(1, 8'(i), 0, 0, "fill8");
    cyc(1, 8'h11, 1, 0, "full_both");
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0, "drain_full");

    // Empty with strobe and ack together.
    cyc(1, 8'h33, 1, 0, "empty_both");
    cyc(0, 8'h00, 1, 0, "ack33");

    // Flush overrides a coincident strobe.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h40 + i), 0, 0, "push5");
    cyc(1, 8'h55, 1, 1, "flush_strobe");
    cyc(1, 8'h10, 0, 0, "p10");
    cyc(0, 8'h00, 1, 0, "ack10");

    // Pointer wrap via push/pop pairs, then overlapped streaming.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 8'(8'h60 + i), 0, 0, "wrap_push");
      cyc(0, 8'h00, 1, 0, "wrap_pop");
    end
    cyc(1, 8'h20, 0, 0, "stream0");
    for (int i = 1; i < 12; i++) cyc(1, 8'(8'h20 + i), 1, 0, "stream");
    cyc(0, 8'h00, 1, 0, "stream_end");

    // Asynchronous reset mid-operation, asserted between edges.
    cyc(1, 8'h01, 0, 0, "pre_rst1");
    cyc(1, 8'h02, 0, 0, "pre_rst2");
    #2;
    rst_an = 1'b0;
    q.delete();
    m_ovf = 1'b0;
    #1;
    chk_state("async_rst");
    @(posedge clk);
    #1;
    rst_an = 1'b1;
    cyc(1, 8'h3C, 0, 0, "post_rst");
    cyc(0, 8'h00, 1, 0, "post_rst_ack");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
